idu1_issue_scoreboard: RTL and testbench

- Parametrised successor to the single-stage decode/issue register.
- Holds one decoded instruction in an issue register and keeps a per-register pending-write scoreboard.
- Issues to EXU over valid/ready only when there are no RAW/WAW hazards and the target functional unit is free.
- Accepts NUM_WB independent writeback ports and handles NUM_UNITS functional-unit classes. This replaces the fixed mul/div/lsu stall special cases.

---
 rtl/idu1_issue_scoreboard_pkg.sv | 27 ++
 rtl/idu1_issue_scoreboard_sb_regfile_pending.sv | 46 ++++
 rtl/idu1_issue_scoreboard.sv | 145 ++++++++++++++
 tb/tb_idu1_issue_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu1_issue_scoreboard_pkg.sv
// Shared types and constants for the decode/issue scoreboard block.
package idu1_issue_scoreboard_pkg;

    localparam int SB_NUM_REGS  = 32;
    localparam int SB_REG_AW    = $clog2(SB_NUM_REGS);
    localparam int SB_PAYLOAD_W = 128;
    localparam int SB_NUM_UNITS = 4;
    localparam int SB_NUM_WB    = 2;

    localparam int UNIT_ALU = 0;
    localparam int UNIT_MUL = 1;
    localparam int UNIT_DIV = 2;
    localparam int UNIT_LSU = 3;

    // Held-instruction layout for the default configuration.
    typedef struct packed {
        logic [SB_PAYLOAD_W-1:0] payload;
        logic [SB_REG_AW-1:0]    rs1_addr;
        logic [SB_REG_AW-1:0]    rs2_addr;
        logic [SB_REG_AW-1:0]    rd_addr;
        logic                    rs1_en;
        logic                    rs2_en;
        logic                    rd_en;
        logic [SB_NUM_UNITS-1:0] unit;
    } idu1_iss_t;

endpackage

// File: rtl/idu1_issue_scoreboard_sb_regfile_pending.sv
// Per-register pending-write vector with writeback clear decode and issue set.
module sb_regfile_pending #(
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = $clog2(NUM_REGS),
    parameter int NUM_WB    = 2,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*REG_AW-1:0] wb_rd_addr,
    input  logic                     set_en,
    input  logic [REG_AW-1:0]        set_addr,
    output logic [NUM_REGS-1:0]      pending,
    output logic [NUM_REGS-1:0]      hz_pending
);

    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] pending_q;

    // Register 0 is never decoded, so it can never become pending.
    always_comb begin
        wb_clr  = '0;
        set_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wb_rd_addr[p*REG_AW +: REG_AW] == REG_AW'(r))
                    wb_clr[r] = 1'b1;
            end
            set_vec[r] = set_en && (set_addr == REG_AW'(r));
        end
    end

    // Set is ORed after the clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk) begin
        if (rst)
            pending_q <= '0;
        else
            pending_q <= (pending_q & ~wb_clr) | set_vec;
    end

    assign pending    = pending_q;
    assign hz_pending = WB_BYPASS ? (pending_q & ~wb_clr) : pending_q;

endmodule

// File: rtl/idu1_issue_scoreboard.sv
// Decode/issue register with RAW/WAW/unit-busy scoreboard.
// Optional same-cycle writeback bypass on the hazard check: IDU1_SB_WB_BYPASS_EN.
module idu1_issue_scoreboard
    import idu1_issue_scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = SB_NUM_REGS,
    parameter int REG_AW    = $clog2(NUM_REGS),
    parameter int PAYLOAD_W = SB_PAYLOAD_W,
    parameter int NUM_UNITS = SB_NUM_UNITS,
    parameter int NUM_WB    = SB_NUM_WB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [PAYLOAD_W-1:0]     dec_payload,
    input  logic                     dec_rs1_en,
    input  logic                     dec_rs2_en,
    input  logic                     dec_rd_en,
    input  logic [REG_AW-1:0]        dec_rs1_addr,
    input  logic [REG_AW-1:0]        dec_rs2_addr,
    input  logic [REG_AW-1:0]        dec_rd_addr,
    input  logic [NUM_UNITS-1:0]     dec_unit,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [PAYLOAD_W-1:0]     iss_payload,
    output logic [REG_AW-1:0]        iss_rs1_addr,
    output logic [REG_AW-1:0]        iss_rs2_addr,
    output logic [REG_AW-1:0]        iss_rd_addr,
    output logic                     iss_rd_en,
    output logic [NUM_UNITS-1:0]     iss_unit,
    input  logic [NUM_UNITS-1:0]     unit_busy,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*REG_AW-1:0] wb_rd_addr,
    output logic [NUM_REGS-1:0]      sb_pending,
    output logic                     stall
);

`ifdef IDU1_SB_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [REG_AW-1:0]    rs1_addr;
        logic [REG_AW-1:0]    rs2_addr;
        logic [REG_AW-1:0]    rd_addr;
        logic                 rs1_en;
        logic                 rs2_en;
        logic                 rd_en;
        logic [NUM_UNITS-1:0] unit;
    } iss_t;

    iss_t                q;
    iss_t                dec_in;
    logic                q_valid;
    logic                hazard;
    logic                iss_fire;
    logic                capture;
    logic [NUM_REGS-1:0] hz_pending;

    always_comb begin
        dec_in.payload  = dec_payload;
        dec_in.rs1_addr = dec_rs1_addr;
        dec_in.rs2_addr = dec_rs2_addr;
        dec_in.rd_addr  = dec_rd_addr;
        dec_in.rs1_en   = dec_rs1_en;
        dec_in.rs2_en   = dec_rs2_en;
        dec_in.rd_en    = dec_rd_en;
        dec_in.unit     = dec_unit;
    end

    assign iss_fire  = iss_valid & iss_ready;
    assign dec_ready = ~q_valid | iss_fire;
    assign capture   = dec_valid & dec_ready & ~flush;

    // Issue register: flush empties it, a new capture overrides an outgoing fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else begin
            if (flush)
                q_valid <= 1'b0;
            else if (capture)
                q_valid <= 1'b1;
            else if (iss_fire)
                q_valid <= 1'b0;
            if (capture)
                q <= dec_in;
        end
    end

    sb_regfile_pending #(
        .NUM_REGS  (NUM_REGS),
        .REG_AW    (REG_AW),
        .NUM_WB    (NUM_WB),
        .WB_BYPASS (WB_BYPASS)
    ) u_pending (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd_addr (wb_rd_addr),
        .set_en     (iss_fire & q.rd_en),
        .set_addr   (q.rd_addr),
        .pending    (sb_pending),
        .hz_pending (hz_pending)
    );

    always_comb begin
        hazard = |(q.unit & unit_busy);
        if (q.rs1_en && q.rs1_addr != '0 && hz_pending[q.rs1_addr]) hazard = 1'b1;
        if (q.rs2_en && q.rs2_addr != '0 && hz_pending[q.rs2_addr]) hazard = 1'b1;
        if (q.rd_en  && q.rd_addr  != '0 && hz_pending[q.rd_addr])  hazard = 1'b1;
    end

    assign iss_valid    = q_valid & ~hazard & ~flush;
    assign stall        = q_valid & hazard;
    assign iss_payload  = q.payload;
    assign iss_rs1_addr = q.rs1_addr;
    assign iss_rs2_addr = q.rs2_addr;
    assign iss_rd_addr  = q.rd_addr;
    assign iss_rd_en    = q.rd_en;
    assign iss_unit     = q.unit;

    // Illegal-usage checks; the datapath deliberately does not mask these.
    for (genvar p = 0; p < NUM_WB; p++) begin : g_wb_chk
        a_wb_pending: assert property (@(posedge clk) disable iff (rst)
            (wb_valid[p] && wb_rd_addr[p*REG_AW +: REG_AW] != '0)
                |-> sb_pending[wb_rd_addr[p*REG_AW +: REG_AW]]);
        for (genvar k = p + 1; k < NUM_WB; k++) begin : g_pair
            a_wb_distinct: assert property (@(posedge clk) disable iff (rst)
                !(wb_valid[p] && wb_valid[k]
                  && wb_rd_addr[p*REG_AW +: REG_AW] == wb_rd_addr[k*REG_AW +: REG_AW]
                  && wb_rd_addr[p*REG_AW +: REG_AW] != '0));
        end
    end

    a_unit_onehot: assert property (@(posedge clk) disable iff (rst)
        dec_valid |-> $onehot(dec_unit));

endmodule

// File: tb/tb_idu1_issue_scoreboard.sv
// Bench for idu1_issue_scoreboard: directed scenarios plus randomized traffic vs. a scoreboard model.
module tb_idu1_issue_scoreboard;
    import idu1_issue_scoreboard_pkg::*;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int PW = 128;
    localparam int NU = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst, flush, dec_valid, dec_ready;
    logic [PW-1:0] dec_payload;
    logic          dec_rs1_en, dec_rs2_en, dec_rd_en;
    logic [AW-1:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic [NU-1:0] dec_unit;
    logic          iss_valid, iss_ready;
    logic [PW-1:0] iss_payload;
    logic [AW-1:0] iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
    logic          iss_rd_en;
    logic [NU-1:0] iss_unit;
    logic [NU-1:0] unit_busy;
    logic [NW-1:0] wb_valid;
    logic [NW*AW-1:0] wb_rd_addr;
    logic [NR-1:0] sb_pending;
    logic          stall;

    always #5 clk = ~clk;

    idu1_issue_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_payload(dec_payload),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rd_en(dec_rd_en),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
        .dec_unit(dec_unit),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr), .iss_rd_addr(iss_rd_addr),
        .iss_rd_en(iss_rd_en), .iss_unit(iss_unit),
        .unit_busy(unit_busy), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .sb_pending(sb_pending), .stall(stall)
    );

    // Reference model: the held instruction and a set of registers awaiting writeback.
    bit            m_qv;
    logic [PW-1:0] m_pay;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    bit            m_rs1_en, m_rs2_en, m_rd_en;
    logic [NU-1:0] m_unit;
    bit            m_pend [NR];

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    function automatic bit wb_hits(int r);
        for (int p = 0; p < NW; p++)
            if (wb_valid[p] && wb_rd_addr[p*AW +: AW] == AW'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit reg_blocks(int r);
        if (r == 0) return 1'b0;
`ifdef IDU1_SB_WB_BYPASS_EN
        return m_pend[r] && !wb_hits(r);
`else
        return m_pend[r];
`endif
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        if (m_rs1_en && reg_blocks(int'(m_rs1))) h = 1'b1;
        if (m_rs2_en && reg_blocks(int'(m_rs2))) h = 1'b1;
        if (m_rd_en  && reg_blocks(int'(m_rd)))  h = 1'b1;
        for (int u = 0; u < NU; u++)
            if (m_unit[u] && unit_busy[u]) h = 1'b1;
        return h;
    endfunction

    function automatic bit exp_iv();
        return m_qv && !m_hazard() && !flush;
    endfunction

    function automatic bit exp_stall();
        return m_qv && m_hazard();
    endfunction

    function automatic bit exp_ready();
        return !m_qv || (exp_iv() && iss_ready);
    endfunction

    function automatic logic [NR-1:0] exp_pend();
        logic [NR-1:0] v = '0;
        for (int r = 0; r < NR; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were held across it.
    task automatic model_step();
        bit fire, cap;
        bit nxt [NR];
        if (rst) begin
            m_qv = 0; m_pay = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_rs1_en = 0; m_rs2_en = 0; m_rd_en = 0; m_unit = '0;
            for (int r = 0; r < NR; r++) m_pend[r] = 0;
        end else begin
            fire = exp_iv() && iss_ready;
            cap  = dec_valid && (!m_qv || fire) && !flush;
            for (int r = 0; r < NR; r++) begin
                nxt[r] = m_pend[r] && !wb_hits(r);
                if (fire && m_rd_en && int'(m_rd) == r && r != 0) nxt[r] = 1;
            end
            for (int r = 0; r < NR; r++) m_pend[r] = nxt[r];
            if (flush)     m_qv = 0;
            else if (cap)  m_qv = 1;
            else if (fire) m_qv = 0;
            if (cap) begin
                m_pay = dec_payload; m_rs1 = dec_rs1_addr; m_rs2 = dec_rs2_addr; m_rd = dec_rd_addr;
                m_rs1_en = dec_rs1_en; m_rs2_en = dec_rs2_en; m_rd_en = dec_rd_en; m_unit = dec_unit;
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("iss_valid",    128'(iss_valid),    128'(exp_iv()));
            chk("stall",        128'(stall),        128'(exp_stall()));
            chk("dec_ready",    128'(dec_ready),    128'(exp_ready()));
            chk("sb_pending",   128'(sb_pending),   128'(exp_pend()));
            chk("iss_payload",  iss_payload,        m_pay);
            chk("iss_rs1_addr", 128'(iss_rs1_addr), 128'(m_rs1));
            chk("iss_rs2_addr", 128'(iss_rs2_addr), 128'(m_rs2));
            chk("iss_rd",       128'({iss_rd_en, iss_rd_addr}), 128'({m_rd_en, m_rd}));
            chk("iss_unit",     128'(iss_unit),     128'(m_unit));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; dec_valid = 0; dec_payload = '0;
        dec_rs1_en = 0; dec_rs2_en = 0; dec_rd_en = 0;
        dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rd_addr = '0;
        dec_unit = 4'b0001; iss_ready = 1; unit_busy = '0;
        wb_valid = '0; wb_rd_addr = '0;
    endtask

    task automatic dec(input bit rs1_en, input int rs1, input bit rd_en, input int rd,
                       input int unit, input logic [PW-1:0] pay);
        dec_valid = 1; dec_payload = pay;
        dec_rs1_en = rs1_en; dec_rs1_addr = AW'(rs1);
        dec_rs2_en = 0;      dec_rs2_addr = '0;
        dec_rd_en = rd_en;   dec_rd_addr = AW'(rd);
        dec_unit = NU'(1) << unit;
    endtask

    initial begin
        int pq[$];
        int i0, i1;
        idle();
        rst = 1;
        tick();
        checking = 1;
        rst = 0;
        dec(1, 5, 1, 6, UNIT_ALU, 128'hA5);
        #2;
        chk("rst_sb_pending", 128'(sb_pending), 128'h0);
        chk("rst_dec_ready",  128'(dec_ready),  128'h1);
        chk("rst_iss_valid",  128'(iss_valid),  128'h0);
        chk("rst_stall",      128'(stall),      128'h0);
        chk("rst_iss_rd",     128'(iss_rd_addr), 128'h0);
        tick(); dec_valid = 0; #2;
        chk("first_iss_valid", 128'(iss_valid),   128'h1);
        chk("first_iss_rd",    128'(iss_rd_addr), 128'h6);
        chk("first_payload",   iss_payload,       128'hA5);
        tick(); #2;
        chk("p6_set",        128'(sb_pending), 128'h40);
        chk("p6_iss_idle",   128'(iss_valid),  128'h0);
        // Dependent consumer rs1=6.
        dec(1, 6, 1, 8, UNIT_ALU, 128'hB1);
        tick(); dec_valid = 0; #2;
        chk("raw_stall",    128'(stall),     128'h1);
        chk("raw_no_issue", 128'(iss_valid), 128'h0);
        tick(); wb_valid = 2'b01; wb_rd_addr = {5'd0, 5'd6}; #2;
`ifdef IDU1_SB_WB_BYPASS_EN
        chk("raw_wb_cycle_iv", 128'(iss_valid), 128'h1);
`else
        chk("raw_wb_cycle_iv", 128'(iss_valid), 128'h0);
`endif
        tick(); wb_valid = '0; #2;
`ifdef IDU1_SB_WB_BYPASS_EN
        chk("raw_after_wb_pend", 128'(sb_pending), 128'h100);
`else
        chk("raw_after_wb_pend", 128'(sb_pending), 128'h0);
        chk("raw_after_wb_iv",   128'(iss_valid),  128'h1);
`endif
        tick(); #2;
        chk("raw_consumer_set", 128'(sb_pending), 128'h100);
        // WAW on r8.
        dec(0, 0, 1, 8, UNIT_ALU, 128'hC3);
        tick(); dec_valid = 0; #2;
        chk("waw_stall", 128'(stall), 128'h1);
        wb_valid = 2'b10; wb_rd_addr = {5'd8, 5'd0};
        tick(); wb_valid = '0;
`ifndef IDU1_SB_WB_BYPASS_EN
        tick();
`endif
        #2;
        chk("waw_reset_pend", 128'(sb_pending), 128'h100);
        chk("waw_drained",    128'(iss_valid),  128'h0);
        // Busy DIV, then flush the stalled op.
        unit_busy = 4'b0100;
        dec(0, 0, 1, 10, UNIT_DIV, 128'hD4);
        tick(); dec_valid = 0; #2;
        chk("div_busy_stall", 128'(stall),     128'h1);
        chk("div_busy_iv",    128'(iss_valid), 128'h0);
        flush = 1; #2;
        chk("flush_iv", 128'(iss_valid), 128'h0);
        tick(); flush = 0; #2;
        chk("flush_ready", 128'(dec_ready),  128'h1);
        chk("flush_stall", 128'(stall),      128'h0);
        chk("flush_sb",    128'(sb_pending), 128'h100);
        dec(0, 0, 1, 11, UNIT_ALU, 128'hE5);
        tick(); dec_valid = 0; #2;
        chk("alu_div_busy_iv",    128'(iss_valid), 128'h1);
        chk("alu_div_busy_stall", 128'(stall),     128'h0);
        tick(); #2;
        chk("two_pending", 128'(sb_pending), 128'h900);
        wb_valid = 2'b11; wb_rd_addr = {5'd11, 5'd8};
        tick(); wb_valid = '0; #2;
        chk("dual_wb_clear", 128'(sb_pending), 128'h0);
        unit_busy = '0;
        dec(1, 0, 1, 0, UNIT_ALU, 128'hF6);
        tick(); dec_valid = 0; #2;
        chk("r0_iv",    128'(iss_valid), 128'h1);
        chk("r0_stall", 128'(stall),     128'h0);
        tick(); #2;
        chk("r0_no_pend", 128'(sb_pending), 128'h0);

        // Randomized traffic; writebacks only target registers the model holds pending.
        repeat (3000) begin
            tick();
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            dec_valid = $urandom_range(0, 1) == 1;
            dec_payload = {$urandom, $urandom, $urandom, $urandom};
            dec_rs1_en = $urandom_range(0, 1) == 1;
            dec_rs2_en = $urandom_range(0, 1) == 1;
            dec_rd_en  = $urandom_range(0, 1) == 1;
            dec_rs1_addr = AW'($urandom_range(0, 7));
            dec_rs2_addr = AW'($urandom_range(0, 7));
            dec_rd_addr  = AW'($urandom_range(0, 7));
            dec_unit  = NU'(1) << $urandom_range(0, NU - 1);
            iss_ready = $urandom_range(0, 3) != 0;
            for (int u = 0; u < NU; u++) unit_busy[u] = ($urandom_range(0, 3) == 0);
            wb_valid = '0; wb_rd_addr = '0;
            pq.delete();
            for (int r = 1; r < NR; r++) if (m_pend[r]) pq.push_back(r);
            if (pq.size() > 0 && $urandom_range(0, 2) == 0) begin
                i0 = $urandom_range(0, pq.size() - 1);
                wb_valid[0] = 1; wb_rd_addr[0 +: AW] = AW'(pq[i0]);
                if (pq.size() > 1 && $urandom_range(0, 1) == 0) begin
                    i1 = (i0 + 1 + $urandom_range(0, pq.size() - 2)) % pq.size();
                    wb_valid[1] = 1; wb_rd_addr[AW +: AW] = AW'(pq[i1]);
                end
            end else if (pq.size() > 0 && $urandom_range(0, 3) == 0) begin
                wb_valid[1] = 1; wb_rd_addr[AW +: AW] = AW'(pq[$urandom_range(0, pq.size() - 1)]);
            end
        end
        idle();
        tick();
        tick();
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
